ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It accepts decoded instructions from decode over a valid/ready handshake and resolves operand forwarding from the MEM and WB stages. It selects immediate vs. register for operand B and presents registered `operand_a`, `operand_b` and `alu_control` to the ALU. A 2-entry skid buffer decouples backpressure so that `in_ready` is a pure register output.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept (registered)
- `in_rs1`, `in_rs2`  in  5  source register indices
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register-file read data
- `in_imm`  in  XLEN  sign-extended immediate
- `in_use_imm`  in  1  1: operand B = immediate
- `in_alu_control`  in  4  ALU opcode (0000 ADD … 1001 AND)
- `in_rd`  in  5  destination register
- `in_reg_write`  in  1  instruction writes `rd`
- `flush`  in  1  discard all buffered and incoming instructions
- `fwd_mem_valid`, `fwd_wb_valid`  in  1  MEM/WB stage holds a writing instruction
- `fwd_mem_rd`, `fwd_wb_rd`  in  5  their destination indices
- `fwd_mem_data`, `fwd_wb_data`  in  XLEN  their result values
- `out_valid`  out  1  `operand_a/b`, `alu_control`, `out_rd`, `out_reg_write` valid
- `out_ready`  in  1  execute consumes this cycle
- `operand_a`, `operand_b`  out  XLEN  ALU operands
- `alu_control`  out  4  ALU opcode
- `out_rd`  out  5, `out_reg_write`  out  1  passed through for writeback

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Forwarding, resolved combinationally at capture, per source `rsN`:
  - MEM match (`fwd_mem_valid && fwd_mem_rd == rsN && rsN != 0`) takes priority.
  - Otherwise a WB match under the same rule.
  - Otherwise `in_rsN_data`.
  - `rsN == 0` always yields the raw data (x0 is never forwarded).
- `operand_b` = `in_use_imm ? in_imm : forwarded rs2`. `operand_a` = forwarded rs1.
- Buffer: main register (drives outputs) plus skid register. States:
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> TWO (capture into skid). Drain without accept -> EMPTY. Both -> ONE (main reloads from input).
  - TWO: `in_ready = 0`. Drain -> ONE (skid moves to main).
- `in_ready` = next-state != TWO, registered.
- Output order is strictly FIFO. No instruction is duplicated or lost.
- `flush`: next state EMPTY, both entries invalid, `out_valid = 0` next cycle, and an input accepted that same cycle is dropped. `flush` wins over all simultaneous events.
- Payload registers update only on capture. Outputs hold stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync deassert by the system):
  - `out_valid = 0`, `in_ready = 1`.
  - `operand_a`, `operand_b`, `out_rd`, `alu_control` = 0. `out_reg_write = 0`. State EMPTY.
- Latency: input accepted at edge N -> `out_valid = 1` after edge N.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- After `out_ready` drops with one entry held, one more input is absorbed. `in_ready` falls the following cycle.
- Reset mid-operation discards all contents immediately. No partial state survives.

## Configuration
- `EX_FORWARDING_EN` defined: forwarding as described above.
- Undefined:
  - All `fwd_*` inputs are ignored and operands come from `in_rsN_data` only.
  - Hazard avoidance is decode's responsibility.
  - Handshake, buffering and timing are unchanged.

## Test plan
- Reset, then one ADDI: rs1=5 data 0x10, imm 0x4, use_imm=1, ctrl 0000, `out_ready=1` -> next cycle `out_valid=1`, `operand_a=0x10`, `operand_b=0x4`, `alu_control=0000`. Prior cycle outputs all 0.
- Forwarding priority: rs1=3, `fwd_mem_rd=3` data 0xAAAA, `fwd_wb_rd=3` data 0xBBBB, both valid -> `operand_a=0xAAAA`. Drop mem_valid -> 0xBBBB. With rs1=0 and matches on rd 0 -> raw data. Without macro, always raw.
- Backpressure: stream I1..I4 with `out_ready=0` from cycle 1 -> I1 held on outputs, I2 in skid, `in_ready=0`. Raise `out_ready` -> I1, I2, I3, I4 in order, none lost or duplicated.
- Flush with TWO entries and `in_valid=1` the same cycle -> next cycle `out_valid=0`, `in_ready=1`, and that input never appears.
- Async reset mid-stream (`rst_n` low between edges) -> `out_valid` and all outputs 0 immediately, `in_ready=1`.
- Random valid/ready toggling over 10k instructions -> output sequence equals input sequence (scoreboard).

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_if
// Bundles every signal that passes between the operand stage and its
// neighbours: the decode-side input handshake and payload, the flush request,
// the MEM/WB forwarding taps, and the ALU-side output handshake and payload.
//
// Modports
//   master : the surrounding pipeline (decode, MEM/WB taps, execute). It drives
//            in_*, flush, fwd_*, out_ready and observes in_ready and the outputs.
//   slave  : the operand stage itself.
// ---------------------------------------------------------------------------
interface ex_operand_stage_if #(
  parameter int XLEN = 32
);
  // decode side
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [3:0]      in_alu_control;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic            flush;
  // forwarding taps
  logic            fwd_mem_valid;
  logic [4:0]      fwd_mem_rd;
  logic [XLEN-1:0] fwd_mem_data;
  logic            fwd_wb_valid;
  logic [4:0]      fwd_wb_rd;
  logic [XLEN-1:0] fwd_wb_data;
  // execute side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [3:0]      alu_control;
  logic [4:0]      out_rd;
  logic            out_reg_write;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_alu_control, in_rd, in_reg_write, flush,
           fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, alu_control,
           out_rd, out_reg_write
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_alu_control, in_rd, in_reg_write, flush,
           fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, operand_a, operand_b, alu_control,
           out_rd, out_reg_write
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX stage in front of the ALU. Captures decoded instructions over a
// valid/ready handshake, resolves MEM/WB operand forwarding at capture time,
// selects immediate or register for operand B, and holds the result in a
// two-entry skid buffer (main register drives the outputs, skid register
// absorbs one extra instruction) so that in_ready comes straight from a flop.
//
// Ports
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_operand_stage_if.slave (decode handshake/payload, flush,
//           forwarding taps, execute handshake/payload)
//
// Build option
//   EX_FORWARDING_EN : when defined, rs1/rs2 are forwarded from MEM (first)
//                      or WB; otherwise the register-file data is used as is.
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_operand_stage_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [4:0]      rd;
    logic            rw;
  } entry_t;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  entry_t          cap;
  logic [XLEN-1:0] src_a, src_b;
  logic            accept, drain;

`ifdef EX_FORWARDING_EN
  // MEM is the younger producer, so it beats WB; x0 is hard-wired zero and
  // must never pick up a forwarded value.
  always_comb begin
    src_a = bus.in_rs1_data;
    if (bus.fwd_mem_valid && bus.fwd_mem_rd == bus.in_rs1 && bus.in_rs1 != 5'd0)
      src_a = bus.fwd_mem_data;
    else if (bus.fwd_wb_valid && bus.fwd_wb_rd == bus.in_rs1 && bus.in_rs1 != 5'd0)
      src_a = bus.fwd_wb_data;

    src_b = bus.in_rs2_data;
    if (bus.fwd_mem_valid && bus.fwd_mem_rd == bus.in_rs2 && bus.in_rs2 != 5'd0)
      src_b = bus.fwd_mem_data;
    else if (bus.fwd_wb_valid && bus.fwd_wb_rd == bus.in_rs2 && bus.in_rs2 != 5'd0)
      src_b = bus.fwd_wb_data;
  end
`else
  // Decode guarantees no hazards reach this stage; the taps are ignored.
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_mem_valid, bus.fwd_mem_rd, bus.fwd_mem_data,
                        bus.fwd_wb_valid, bus.fwd_wb_rd, bus.fwd_wb_data,
                        bus.in_rs1, bus.in_rs2};
  assign src_a = bus.in_rs1_data;
  assign src_b = bus.in_rs2_data;
`endif

  always_comb begin
    cap.a    = src_a;
    cap.b    = bus.in_use_imm ? bus.in_imm : src_b;
    cap.ctrl = bus.in_alu_control;
    cap.rd   = bus.in_rd;
    cap.rw   = bus.in_reg_write;
  end

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = cap;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = cap;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = cap;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides everything, including a capture in the same cycle;
    // payload is left untouched because out_valid already hides it.
    if (bus.flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (state_q != ST_EMPTY);
  assign bus.operand_a     = main_q.a;
  assign bus.operand_b     = main_q.b;
  assign bus.alu_control   = main_q.ctrl;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_reg_write = main_q.rw;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Directed bench for ex_operand_stage followed by a random valid/ready stream
// checked against a FIFO scoreboard. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NRND  = 10000;
  localparam int MAXCYC = 60000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  ex_operand_stage_if #(.XLEN(32)) bus ();
  ex_operand_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [9:0]  tail;   // {ctrl, rd, reg_write}
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [4:0] rd, input logic rw);
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_a"}, bus.operand_a, a);
    check({tag, "_b"}, bus.operand_b, b);
    check({tag, "_tail"}, {bus.alu_control, bus.out_rd, bus.out_reg_write}, {c, rd, rw});
    $display("txn %s: a=%h b=%h ctrl=%h rd=%0d rw=%0b", tag, bus.operand_a,
             bus.operand_b, bus.alu_control, bus.out_rd, bus.out_reg_write);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 1'b0);
    check({tag, "_ready"}, bus.in_ready, 1'b1);
    check({tag, "_a"}, bus.operand_a, 32'h0);
    check({tag, "_b"}, bus.operand_b, 32'h0);
    check({tag, "_tail"}, {bus.alu_control, bus.out_rd, bus.out_reg_write}, 10'h0);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic ui, input logic [3:0] c, input logic [4:0] rd,
                       input logic rw);
    bus.in_valid = v;   bus.in_rs1 = rs1;  bus.in_rs1_data = d1;
    bus.in_rs2 = rs2;   bus.in_rs2_data = d2; bus.in_imm = imm;
    bus.in_use_imm = ui; bus.in_alu_control = c; bus.in_rd = rd;
    bus.in_reg_write = rw;
  endtask

  task automatic set_fwd(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    bus.fwd_mem_valid = mv; bus.fwd_mem_rd = mrd; bus.fwd_mem_data = md;
    bus.fwd_wb_valid = wv;  bus.fwd_wb_rd = wrd;  bus.fwd_wb_data = wd;
  endtask

  // Instruction tagged by k: rs1_data = 0x100+k, imm = 0x200+k, operand_b = imm.
  task automatic drive_item(input int k);
    drive(1'b1, 5'd1, 32'h100 + k, 5'd2, 32'h0, 32'h200 + k, 1'b1, k[3:0], k[4:0], 1'b1);
  endtask

  task automatic check_item(input string tag, input int k);
    check_out(tag, 32'h100 + k, 32'h200 + k, k[3:0], k[4:0], 1'b1);
  endtask

  initial begin
    exp_t q[$];
    exp_t e;
    int   sent;
    int   got;
    int   cycles;

    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // reset state
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // single ADDI
    @(negedge clk);
    check_zero("pre_addi");
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd5, 32'h10, 5'd0, 32'h0, 32'h4, 1'b1, 4'b0000, 5'd7, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("addi", 32'h10, 32'h4, 4'b0000, 5'd7, 1'b1);
    @(negedge clk);
    check("addi_drained", bus.out_valid, 1'b0);

    // forwarding priority, back-to-back at full throughput
    set_fwd(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    drive(1'b1, 5'd3, 32'h1111, 5'd4, 32'h2222, 32'h0, 1'b0, 4'b0010, 5'd8, 1'b1);
    @(negedge clk);
    check_out("fwd_mem", FWD ? 32'hAAAA : 32'h1111, 32'h2222, 4'b0010, 5'd8, 1'b1);
    set_fwd(1'b0, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    drive(1'b1, 5'd3, 32'h1111, 5'd3, 32'h2222, 32'h0, 1'b0, 4'b1001, 5'd9, 1'b0);
    @(negedge clk);
    check_out("fwd_wb", FWD ? 32'hBBBB : 32'h1111, FWD ? 32'hBBBB : 32'h2222,
              4'b1001, 5'd9, 1'b0);
    set_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
    drive(1'b1, 5'd0, 32'h3333, 5'd0, 32'h4444, 32'h0, 1'b0, 4'b0001, 5'd10, 1'b1);
    @(negedge clk);
    check_out("fwd_x0", 32'h3333, 32'h4444, 4'b0001, 5'd10, 1'b1);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fwd_drained", bus.out_valid, 1'b0);

    // backpressure: I1..I4 with out_ready low from the first cycle
    bus.out_ready = 1'b0;
    drive_item(1);
    @(negedge clk);
    check_item("bp_i1_first", 1);
    check("bp_ready_one", bus.in_ready, 1'b1);
    drive_item(2);
    @(negedge clk);
    check_item("bp_i1_hold", 1);
    check("bp_ready_two", bus.in_ready, 1'b0);
    drive_item(3);
    @(negedge clk);
    check_item("bp_i1_stall", 1);
    check("bp_ready_stall", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_item("bp_i2", 2);
    check("bp_ready_reopen", bus.in_ready, 1'b1);
    @(negedge clk);
    check_item("bp_i3", 3);
    drive_item(4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_item("bp_i4", 4);
    @(negedge clk);
    check("bp_drained", bus.out_valid, 1'b0);

    // flush with two entries and a simultaneous input
    bus.out_ready = 1'b0;
    drive_item(5);
    @(negedge clk);
    drive_item(6);
    @(negedge clk);
    check("fl_two_ready", bus.in_ready, 1'b0);
    bus.flush = 1'b1;
    drive_item(7);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_two_valid", bus.out_valid, 1'b0);
    check("fl_two_ready_after", bus.in_ready, 1'b1);

    // flush in ONE while an input is actually accepted: it must vanish
    drive_item(8);
    @(negedge clk);
    bus.flush = 1'b1;
    drive_item(9);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("fl_one_valid", bus.out_valid, 1'b0);
    check("fl_one_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check("fl_one_gone", bus.out_valid, 1'b0);
    drive_item(10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_item("fl_next", 10);
    @(negedge clk);
    check("fl_next_drained", bus.out_valid, 1'b0);

    // asynchronous reset between edges while holding two entries
    bus.out_ready = 1'b0;
    drive_item(11);
    @(negedge clk);
    drive_item(12);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_item("ar_pre", 11);
    #2 rst_n = 1'b0;
    #1 check_zero("ar_now");
    @(negedge clk);
    check_zero("ar_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("ar_released");

    // random valid/ready stream against a FIFO scoreboard
    sent = 0;
    got = 0;
    cycles = 0;
    while ((sent < NRND || q.size() != 0) && cycles < MAXCYC) begin
      @(negedge clk);
      cycles++;
      check("rnd_valid", bus.out_valid, q.size() != 0);
      check("rnd_ready", bus.in_ready, q.size() < 2);
      drive((sent < NRND) && ($urandom_range(0, 3) != 0), 5'($urandom_range(1, 31)),
            $urandom, 5'($urandom_range(1, 31)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("rnd_underflow", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("rnd_a", bus.operand_a, e.a);
          check("rnd_b", bus.operand_b, e.b);
          check("rnd_tail", {bus.alu_control, bus.out_rd, bus.out_reg_write}, e.tail);
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.a = bus.in_rs1_data;
        e.b = bus.in_use_imm ? bus.in_imm : bus.in_rs2_data;
        e.tail = {bus.in_alu_control, bus.in_rd, bus.in_reg_write};
        q.push_back(e);
        sent++;
      end
    end
    check("rnd_timeout", cycles < MAXCYC, 1'b1);
    check("rnd_count", got, NRND);
    $display("random stream: sent=%0d received=%0d cycles=%0d", sent, got, cycles);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
